// File: rtl/periph_req_router_pkg.sv
// SoC slave address map shared by every bus master that decodes peripheral addresses.
package periph_req_router_pkg;

  localparam int unsigned SocNbPeripherals = 17;

  // Slave index order; DRAM is the lowest index and wins on any overlap.
  typedef enum int unsigned {
    SlvDram     = 0,
    SlvGpio     = 1,
    SlvEthernet = 2,
    SlvSpi      = 3,
    SlvTimer    = 4,
    SlvHmac     = 5,
    SlvKmac     = 6,
    SlvOtbn     = 7,
    SlvKeymgr   = 8,
    SlvRng      = 9,
    SlvAcc      = 10,
    SlvAes      = 11,
    SlvUart     = 12,
    SlvPlic     = 13,
    SlvClint    = 14,
    SlvRom      = 15,
    SlvDebug    = 16
  } soc_slave_e;

  localparam logic [63:0] SocBase [SocNbPeripherals] = '{
    64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
    64'h1800_0000, 64'h1070_0000, 64'h1060_0000, 64'h1050_0000,
    64'h1040_0000, 64'h1030_0000, 64'h1020_0000, 64'h1010_0000,
    64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000,
    64'h0000_0000
  };

  localparam logic [63:0] SocLength [SocNbPeripherals] = '{
    64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000,
    64'h0000_1000, 64'h0000_1000, 64'h0000_1000, 64'h0000_1000,
    64'h0000_1000, 64'h0000_1000, 64'h0000_1000, 64'h0000_1000,
    64'h0000_1000, 64'h0400_0000, 64'h000C_0000, 64'h0001_0000,
    64'h0000_1000
  };

  // Region hit; the 65-bit end keeps a region touching 2^64 from wrapping.
  function automatic logic in_region(logic [63:0] addr, logic [63:0] base, logic [63:0] len);
    logic [64:0] end_addr;
    end_addr = {1'b0, base} + {1'b0, len};
    return (addr >= base) && ({1'b0, addr} < end_addr);
  endfunction

  // Permission bit position for a privilege level; the reserved level 2 maps to U.
  function automatic logic [1:0] priv_sel(logic [1:0] priv);
    case (priv)
      2'd1:    return 2'd1;
      2'd3:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/periph_addr_match.sv
// Combinational address decoder: one-hot slave select, index and offset from the slave base.
module periph_addr_match
  import periph_req_router_pkg::*;
#(
  parameter int unsigned NbSlaves = SocNbPeripherals,
  parameter int unsigned IdxW     = $clog2(NbSlaves)
) (
  input  logic [63:0]         i_addr,
  output logic                o_hit,
  output logic [NbSlaves-1:0] o_onehot,
  output logic [IdxW-1:0]     o_idx,
  output logic [63:0]         o_offset
);

  // Scan from the top index down so the lowest matching index is the one left standing.
  always_comb begin
    o_hit    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    o_offset = '0;
    for (int i = int'(NbSlaves) - 1; i >= 0; i--) begin
      if (in_region(i_addr, SocBase[i], SocLength[i])) begin
        o_hit       = 1'b1;
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IdxW'(i);
        o_offset    = i_addr - SocBase[i];
      end
    end
  end

endmodule

// File: rtl/periph_req_router.sv
// Single-outstanding router from the core peripheral port to one of the SoC slaves,
// with decode/privilege error responses and a bounded slave transaction time.
module periph_req_router
  import periph_req_router_pkg::*;
#(
  parameter int unsigned NB_PERIPHERALS = SocNbPeripherals,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  output logic                           gnt_o,
  input  logic                           we_i,
  input  logic [63:0]                    addr_i,
  input  logic [31:0]                    wdata_i,
  input  logic [3:0]                     be_i,
  input  logic [1:0]                     priv_i,
  output logic                           rvalid_o,
  output logic [31:0]                    rdata_o,
  output logic                           err_o,
  input  logic [NB_PERIPHERALS*3-1:0]    allow_i,
  output logic [NB_PERIPHERALS-1:0]      slv_req_o,
  output logic                           slv_we_o,
  output logic [31:0]                    slv_wdata_o,
  output logic [3:0]                     slv_be_o,
  output logic [63:0]                    slv_addr_o,
  input  logic [NB_PERIPHERALS-1:0]      slv_gnt_i,
  input  logic [NB_PERIPHERALS-1:0]      slv_rvalid_i,
  input  logic [NB_PERIPHERALS*32-1:0]   slv_rdata_i
);

  localparam int unsigned IdxW = $clog2(NB_PERIPHERALS);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StResp} state_e;

  state_e                    r_state;
  logic [CntW-1:0]           r_cnt;
  logic [IdxW-1:0]           r_idx;
  logic                      r_we;
  logic [63:0]               r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_be;
  logic [1:0]                r_priv;
  logic [NB_PERIPHERALS-1:0] r_slv_req;
  logic [63:0]               r_slv_addr;
  logic                      r_rvalid;
  logic                      r_err;
  logic [31:0]               r_rdata;

  logic                      w_hit;
  logic [NB_PERIPHERALS-1:0] w_onehot;
  logic [IdxW-1:0]           w_idx;
  logic [63:0]               w_offset;
  logic [IdxW+1:0]           w_allow_base;
  logic [2:0]                w_allow_sel;
  logic                      w_perm_ok;
  logic                      w_decode_err;
  logic [IdxW+4:0]           w_rdata_base;
  logic                      w_gnt_sel;
  logic                      w_rvalid_sel;
  logic [31:0]               w_rdata_sel;
  logic                      w_timeout;

  periph_addr_match #(
    .NbSlaves (NB_PERIPHERALS),
    .IdxW     (IdxW)
  ) u_addr_match (
    .i_addr   (r_addr),
    .o_hit    (w_hit),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_offset (w_offset)
  );

  // 3*idx without a multiplier.
  assign w_allow_base = {2'b00, w_idx} + {1'b0, w_idx, 1'b0};
  assign w_allow_sel  = allow_i[w_allow_base +: 3];
  assign w_perm_ok    = w_allow_sel[priv_sel(r_priv)];
  assign w_decode_err = !w_hit || (r_addr[1:0] != 2'b00) || !w_perm_ok;

  assign w_rdata_base = {r_idx, 5'b00000};
  assign w_gnt_sel    = slv_gnt_i[r_idx];
  assign w_rvalid_sel = slv_rvalid_i[r_idx];
  assign w_rdata_sel  = slv_rdata_i[w_rdata_base +: 32];
  assign w_timeout    = (r_cnt == TimeoutCnt);

  // Only combinational path from an input; masked during reset so it reads 0.
  assign gnt_o = req_i && (r_state == StIdle) && !rst_i;

  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign slv_req_o   = r_slv_req;
  assign slv_we_o    = r_we;
  assign slv_wdata_o = r_wdata;
  assign slv_be_o    = r_be;
  assign slv_addr_o  = r_slv_addr;

  // Request FSM with registered upstream response and slave request outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_priv     <= '0;
      r_slv_req  <= '0;
      r_slv_addr <= '0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rvalid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
            r_priv  <= priv_i;
            r_state <= StCheck;
          end
        end
        StCheck: begin
          r_cnt <= '0;
          if (w_decode_err) begin
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 1'b1;
            r_state  <= StResp;
          end else begin
            r_idx      <= w_idx;
            r_slv_req  <= w_onehot;
            r_slv_addr <= w_offset;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          if (!w_timeout) r_cnt <= r_cnt + 1'b1;
          // A grant in the timeout cycle still counts as accepted.
          if (w_gnt_sel) begin
            r_slv_req <= '0;
            r_state   <= StWait;
          end else if (w_timeout) begin
            r_slv_req <= '0;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_rvalid  <= 1'b1;
            r_state   <= StResp;
          end
        end
        StWait: begin
          if (!w_timeout) r_cnt <= r_cnt + 1'b1;
          if (w_rvalid_sel) begin
            r_err    <= 1'b0;
            r_rdata  <= r_we ? 32'h0 : w_rdata_sel;
            r_rvalid <= 1'b1;
            r_state  <= StResp;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 1'b1;
            r_state  <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
